// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//
// Instruction-fetch controller placed directly after the PC register. It
// issues the current PC on an SRAM-like instruction bus, delivers the returned
// word to the F/D register, holds that word while decode is stalled, and drops
// responses that belong to a fetch abandoned by a flush. It also drives the
// PC register enable, so the PC advances once per delivered instruction.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   pcF               current fetch PC (PC register output)
//   stallF            decode cannot accept an instruction this cycle
//   flushF            redirect; the PC register loads a new PC this edge
//   pc_enF            enable to the PC register
//   inst_req          fetch request
//   inst_addr         fetch address (always pcF)
//   inst_addr_ok      request accepted this cycle
//   inst_data_ok      read data valid this cycle
//   inst_rdata        read data
//   instrF            instruction to the F/D register
//   instr_validF      instrF valid this cycle
//   addr_errF         instrF belongs to a misaligned PC
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pcF,
    input  logic              stallF,
    input  logic              flushF,
    output logic              pc_enF,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic [DATA_W-1:0] instrF,
    output logic              instr_validF,
    output logic              addr_errF
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_err_q, buf_err_d;
    logic              aligned;

    assign aligned   = (pcF[1:0] == 2'b00);
    assign inst_addr = pcF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_REQ;
            buf_q     <= '0;
            buf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            buf_err_q <= buf_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_err_d    = buf_err_q;
        inst_req     = 1'b0;
        instr_validF = 1'b0;
        instrF       = '0;
        addr_errF    = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (aligned) begin
                    // Request held until accepted; PC is frozen meanwhile.
                    inst_req = 1'b1;
                    if (inst_addr_ok) begin
                        state_d = flushF ? S_DISCARD : S_WAIT;
                    end
                end else begin
                    // Misaligned PC never reaches the bus; deliver a NOP flagged AdEL.
                    instrF       = NOP_WORD;
                    instr_validF = 1'b1;
                    addr_errF    = 1'b1;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    instrF       = inst_rdata;
                    instr_validF = 1'b1;
                    if (flushF) begin
                        state_d = S_REQ;
                    end else if (stallF) begin
                        state_d   = S_HOLD;
                        buf_d     = inst_rdata;
                        buf_err_d = 1'b0;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (flushF) begin
                    // Response still owed by the bus; swallow it later.
                    state_d = S_DISCARD;
                end
            end
            S_HOLD: begin
                instrF       = buf_q;
                instr_validF = 1'b1;
                addr_errF    = buf_err_q;
                if (flushF || !stallF) begin
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (inst_data_ok) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (flushF) begin
            instr_validF = 1'b0;
            addr_errF    = 1'b0;
        end

        // Keep every output quiet while reset is asserted.
        if (!rst) begin
            inst_req     = 1'b0;
            instr_validF = 1'b0;
            addr_errF    = 1'b0;
            instrF       = '0;
        end
    end

    assign pc_enF = instr_validF & ~stallF & ~flushF;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic        stallF;
    logic        flushF;
    logic        pc_enF;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] instrF;
    logic        instr_validF;
    logic        addr_errF;

    int checks = 0;
    int passed = 0;

    // Scoreboard entries are {addr_err, word}.
    logic [32:0] exp_q[$];

    if_fetch_ctrl #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .NOP_WORD (32'h00000000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pcF          (pcF),
        .stallF       (stallF),
        .flushF       (flushF),
        .pc_enF       (pc_enF),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .instrF       (instrF),
        .instr_validF (instr_validF),
        .addr_errF    (addr_errF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: sampled 1 time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (instr_validF === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got instr %h err %b, scoreboard empty",
                         instrF, addr_errF);
            end else begin
                if ({addr_errF, instrF} !== exp_q[0])
                    $display("FAIL sb_data: got %h want %h", {addr_errF, instrF}, exp_q[0]);
                else
                    passed++;
                if (pc_enF === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc();
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF, addr_errF, instrF} !== 36'h0)
            $display("FAIL reset_misaligned: got req/val/en/err %b%b%b%b instr %h want 0",
                     inst_req, instr_validF, pc_enF, addr_errF, instrF);
        else passed++;
        cyc();
        pcF = 32'hbfc00000;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF} !== 3'b000)
            $display("FAIL reset_aligned: got %b%b%b want 000", inst_req, instr_validF, pc_enF);
        else passed++;
        checks++;
        if (inst_addr !== 32'hbfc00000)
            $display("FAIL reset_addr: got %h want bfc00000", inst_addr);
        else passed++;
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF} !== 3'b100)
            $display("FAIL reset_release: got %b%b%b want 100", inst_req, instr_validF, pc_enF);
        else passed++;
    endtask

    task automatic test_basic();
        cyc();
        inst_addr_ok = 1'b1;
        #1;
        checks++;
        if ({inst_req, pc_enF, inst_addr} !== {2'b10, 32'hbfc00000})
            $display("FAIL basic_req: got %b%b %h want 10 bfc00000", inst_req, pc_enF, inst_addr);
        else passed++;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h3c080001;
        exp_q.push_back({1'b0, 32'h3c080001});
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF, instrF} !== {3'b011, 32'h3c080001})
            $display("FAIL basic_data: got %b%b%b %h want 011 3c080001",
                     inst_req, instr_validF, pc_enF, instrF);
        else passed++;
        cyc();
        inst_data_ok = 1'b0;
        pcF = 32'hbfc00004;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF, inst_addr} !== {3'b100, 32'hbfc00004})
            $display("FAIL basic_next: got %b%b%b %h want 100 bfc00004",
                     inst_req, instr_validF, pc_enF, inst_addr);
        else passed++;
    endtask

    task automatic test_stall();
        cyc();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h24090005;
        stallF       = 1'b1;
        exp_q.push_back({1'b0, 32'h24090005});
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF, instrF} !== {3'b010, 32'h24090005})
            $display("FAIL stall_data: got %b%b%b %h want 010 24090005",
                     inst_req, instr_validF, pc_enF, instrF);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            cyc();
            inst_data_ok = 1'b0;
            inst_rdata   = 32'h0;
            #1;
            checks++;
            if ({inst_req, instr_validF, pc_enF, instrF} !== {3'b010, 32'h24090005})
                $display("FAIL stall_hold: got %b%b%b %h want 010 24090005",
                         inst_req, instr_validF, pc_enF, instrF);
            else passed++;
        end
        cyc();
        stallF = 1'b0;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF, instrF} !== {3'b011, 32'h24090005})
            $display("FAIL stall_release: got %b%b%b %h want 011 24090005",
                     inst_req, instr_validF, pc_enF, instrF);
        else passed++;
        cyc();
        pcF = 32'hbfc00008;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF} !== 3'b100)
            $display("FAIL stall_next: got %b%b%b want 100", inst_req, instr_validF, pc_enF);
        else passed++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            cyc();
            stallF       = (i == 1);
            inst_addr_ok = 1'b0;
            #1;
            checks++;
            if ({inst_req, instr_validF, pc_enF, inst_addr} !== {3'b100, 32'hbfc00008})
                $display("FAIL bp_wait: got %b%b%b %h want 100 bfc00008",
                         inst_req, instr_validF, pc_enF, inst_addr);
            else passed++;
        end
        cyc();
        stallF       = 1'b0;
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h8c820000;
        exp_q.push_back({1'b0, 32'h8c820000});
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF} !== 3'b011)
            $display("FAIL bp_data: got %b%b%b want 011", inst_req, instr_validF, pc_enF);
        else passed++;
        cyc();
        inst_data_ok = 1'b0;
        pcF = 32'hbfc0000c;
    endtask

    task automatic test_flush_inflight();
        cyc();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        flushF       = 1'b1;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF} !== 3'b000)
            $display("FAIL fl_flush: got %b%b%b want 000", inst_req, instr_validF, pc_enF);
        else passed++;
        cyc();
        flushF = 1'b0;
        pcF    = 32'hbfc00380;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF} !== 3'b000)
            $display("FAIL fl_discard: got %b%b%b want 000", inst_req, instr_validF, pc_enF);
        else passed++;
        cyc();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hdeadbeef;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF} !== 3'b000)
            $display("FAIL fl_drop: got %b%b%b want 000", inst_req, instr_validF, pc_enF);
        else passed++;
        cyc();
        inst_data_ok = 1'b0;
        #1;
        checks++;
        if ({inst_req, instr_validF, inst_addr} !== {2'b10, 32'hbfc00380})
            $display("FAIL fl_newreq: got %b%b %h want 10 bfc00380",
                     inst_req, instr_validF, inst_addr);
        else passed++;
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h40806000;
        exp_q.push_back({1'b0, 32'h40806000});
        cyc();
        inst_data_ok = 1'b0;
        pcF = 32'hbfc00384;
    endtask

    task automatic test_flush_hold();
        cyc();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h11111111;
        stallF       = 1'b1;
        exp_q.push_back({1'b0, 32'h11111111});
        cyc();
        inst_data_ok = 1'b0;
        flushF       = 1'b1;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF} !== 3'b000)
            $display("FAIL fh_flush: got %b%b%b want 000", inst_req, instr_validF, pc_enF);
        else passed++;
        cyc();
        flushF = 1'b0;
        stallF = 1'b0;
        void'(exp_q.pop_front());
        pcF = 32'hbfc00380;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF} !== 3'b100)
            $display("FAIL fh_req: got %b%b%b want 100", inst_req, instr_validF, pc_enF);
        else passed++;
    endtask

    task automatic test_flush_req();
        // Unaccepted request abandoned: stays in S_REQ.
        cyc();
        flushF = 1'b1;
        #1;
        checks++;
        if ({instr_validF, pc_enF} !== 2'b00)
            $display("FAIL fr_noack: got %b%b want 00", instr_validF, pc_enF);
        else passed++;
        cyc();
        flushF = 1'b0;
        pcF    = 32'hbfc00400;
        #1;
        checks++;
        if ({inst_req, inst_addr} !== {1'b1, 32'hbfc00400})
            $display("FAIL fr_rereq: got %b %h want 1 bfc00400", inst_req, inst_addr);
        else passed++;
        // Accepted request on the flush cycle: its response must be swallowed.
        inst_addr_ok = 1'b1;
        flushF       = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        flushF       = 1'b0;
        pcF          = 32'hbfc00380;
        #1;
        checks++;
        if ({inst_req, instr_validF} !== 2'b00)
            $display("FAIL fr_discard: got %b%b want 00", inst_req, instr_validF);
        else passed++;
        cyc();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hcafef00d;
        cyc();
        inst_data_ok = 1'b0;
        #1;
        checks++;
        if ({inst_req, instr_validF} !== 2'b10)
            $display("FAIL fr_back: got %b%b want 10", inst_req, instr_validF);
        else passed++;
    endtask

    task automatic test_misaligned();
        cyc();
        pcF    = 32'hbfc00002;
        stallF = 1'b1;
        exp_q.push_back({1'b1, 32'h00000000});
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF, addr_errF, instrF} !== {4'b0101, 32'h0})
            $display("FAIL mis_stall: got %b%b%b%b %h want 0101 00000000",
                     inst_req, instr_validF, pc_enF, addr_errF, instrF);
        else passed++;
        cyc();
        stallF = 1'b0;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF, addr_errF} !== 4'b0111)
            $display("FAIL mis_adv: got %b%b%b%b want 0111",
                     inst_req, instr_validF, pc_enF, addr_errF);
        else passed++;
        cyc();
        pcF = 32'hbfc00008;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF, addr_errF} !== 4'b1000)
            $display("FAIL mis_next: got %b%b%b%b want 1000",
                     inst_req, instr_validF, pc_enF, addr_errF);
        else passed++;
    endtask

    task automatic test_reset_mid();
        cyc();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        rst          = 1'b0;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF} !== 3'b000)
            $display("FAIL rm_reset: got %b%b%b want 000", inst_req, instr_validF, pc_enF);
        else passed++;
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if ({inst_req, instr_validF, pc_enF} !== 3'b100)
            $display("FAIL rm_release: got %b%b%b want 100", inst_req, instr_validF, pc_enF);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            cyc();
            inst_data_ok = 1'b0;
            pcF          = 32'hbfc00100 + 32'(4 * i);
            inst_addr_ok = 1'b1;
            #1;
            checks++;
            if ({inst_req, instr_validF, pc_enF, inst_addr} !== {3'b100, pcF})
                $display("FAIL b2b_req: got %b%b%b %h want 100 %h",
                         inst_req, instr_validF, pc_enF, inst_addr, pcF);
            else passed++;
            cyc();
            w            = $urandom;
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b1;
            inst_rdata   = w;
            exp_q.push_back({1'b0, w});
            #1;
            checks++;
            if ({inst_req, instr_validF, pc_enF} !== 3'b011)
                $display("FAIL b2b_data: got %b%b%b want 011", inst_req, instr_validF, pc_enF);
            else passed++;
        end
        cyc();
        inst_data_ok = 1'b0;
        pcF = 32'hbfc00110;
    endtask

    initial begin
        rst          = 1'b0;
        pcF          = 32'hbfc00002;
        stallF       = 1'b0;
        flushF       = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;

        test_reset();
        test_basic();
        test_stall();
        test_backpressure();
        test_flush_inflight();
        test_flush_hold();
        test_flush_req();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();

        cyc();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL sb_drain: got %0d pending entries want 0", exp_q.size());
        else passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller that sits directly downstream of the PC register. It takes the current fetch address (the PC register's q), issues it on an SRAM-like instruction bus (req/addr_ok/data_ok), and delivers the returned word to the F/D pipeline register. It buffers the word while decode is stalled and drops in-flight responses after a flush. It also generates the PC register's en.

Parameters:
ADDR_W, 32, fetch address width
DATA_W, 32, instruction word width
NOP_WORD, 32'h00000000, word delivered on a misaligned fetch

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset)
pcF  input  ADDR_W  current fetch PC (PC register output)
stallF  input  1  decode cannot accept an instruction this cycle
flushF  input  1  exception/redirect; PC register loads newPCF this edge
pc_enF  output  1  en to the PC register
inst_req  output  1  fetch request
inst_addr  output  ADDR_W  fetch address
inst_addr_ok  input  1  request accepted this cycle
inst_data_ok  input  1  read data valid this cycle
inst_rdata  input  DATA_W  read data
instrF  output  DATA_W  instruction to the F/D register
instr_validF  output  1  instrF valid this cycle
addr_errF  output  1  instrF belongs to a misaligned PC (AdEL)

Behaviour:
- States: S_REQ, S_WAIT, S_HOLD, S_DISCARD.
- Reset (rst=0, async) puts the block in:
  - state S_REQ, holding buffer = 0, buffer addr_err flag = 0.
  - Combinational outputs evaluate to: inst_req=0, instr_validF=0, pc_enF=0, addr_errF=0, instrF=0.
  - Outputs stay in that condition while rst=0.
- inst_addr = pcF, always (combinational).
- At most one outstanding request. Bus guarantees data_ok arrives no earlier than the cycle after addr_ok.
- S_REQ, pcF[1:0]==0:
  - inst_req=1. Request is held until addr_ok; pc_enF=0 holds pcF stable.
  - addr_ok=1 -> S_WAIT.
- S_REQ, pcF[1:0]!=0 (misaligned):
  - inst_req=0. instrF=NOP_WORD, instr_validF=1, addr_errF=1.
  - Stays in S_REQ; the next PC is taken on the advance.
- S_WAIT:
  - inst_req=0.
  - data_ok=1: instrF=inst_rdata (combinational bypass), instr_validF=1.
    - stallF=0 -> S_REQ.
    - stallF=1 -> capture inst_rdata in the buffer, go to S_HOLD.
- S_HOLD:
  - instrF=buffer, instr_validF=1.
  - stallF=0 -> S_REQ.
- Advance: pc_enF = instr_validF & ~stallF & ~flushF. Exactly one PC advance per delivered instruction.
- Latency: best case, the request cycle plus the data cycle, giving a 2-cycle fetch; back-to-back throughput is 1 instruction per 2 cycles.
- flushF=1 takes priority over all stall/advance handling:
  - Forces instr_validF=0 and pc_enF=0 that cycle.
  - S_REQ, no addr_ok (or misaligned) -> S_REQ. The unaccepted request is abandoned; the new PC is requested next cycle.
  - S_REQ with addr_ok -> S_DISCARD.
  - S_WAIT, no data_ok -> S_DISCARD.
  - S_WAIT with data_ok -> S_REQ; the data is dropped.
  - S_HOLD -> S_REQ; the buffer is invalidated.
  - S_DISCARD -> S_DISCARD.
- S_DISCARD:
  - inst_req=0, instr_validF=0.
  - data_ok=1 -> S_REQ; the data is dropped, never delivered.
- stallF is ignored in S_DISCARD and while a request is pending in S_REQ.
- Reset mid-transaction returns the block to S_REQ. The bus is reset by the same rst.

Test Plan:
- Reset release: pcF=32'hbfc00000, addr_ok next cycle, data_ok the cycle after with rdata=32'h3c080001 -> inst_req=1 only in S_REQ; instrF=32'h3c080001, instr_validF=1 and pc_enF=1 for exactly 1 cycle.
- Stall at delivery: data_ok with rdata=32'h24090005 while stallF=1 for 3 cycles -> instr_validF=1 and instrF=32'h24090005 for all 4 cycles; pc_enF=0 for the 3 stalled cycles, then 1 for a single cycle; no new inst_req until S_REQ.
- Slave backpressure: addr_ok held 0 for 4 cycles -> inst_req=1 and inst_addr unchanged for all 4 cycles; pc_enF=0 throughout.
- Flush in flight: addr_ok accepted, flushF=1 the next cycle with pcF changing to 32'hbfc00380, data_ok 2 cycles later -> that data is never valid; the next inst_req is issued with inst_addr=32'hbfc00380.
- Flush during hold: S_HOLD, flushF=1 -> instr_validF=0 and pc_enF=0 that cycle; the following cycle is in S_REQ with inst_req=1.
- Misaligned: pcF=32'hbfc00002 -> inst_req=0, instrF=0, addr_errF=1, instr_validF=1; pc_enF=1 once stallF=0.
